// File: rtl/desched_pkg.sv
// Shared types and constants for the receive side of the 4-channel scheduler link.
package desched_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int NUM_CH      = 4;
  localparam int PTR_W       = 2;
  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 16;
  localparam int IDLE_W      = 8;

endpackage

// File: rtl/desched_idle_timer.sv
// Idle timer for partial frames: holds the number of idle cycles still tolerated
// and strobes expire on the idle cycle that exhausts it.
module desched_idle_timer
  import desched_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [IDLE_W-1:0] RELOAD = IDLE_W'(TIMEOUT - 1);

  logic [IDLE_W-1:0] remain;

  assign expire = en && (remain == '0);

  // Reload on expiry so a fresh partial frame always gets the full budget.
  always_ff @(posedge clk) begin
    if (!rst) begin
      remain <= RELOAD;
    end else if (clr || expire) begin
      remain <= RELOAD;
    end else if (en) begin
      remain <= remain - IDLE_W'(1);
    end
  end

endmodule

// File: rtl/descheduler.sv
// Rebuilds channel registers r0..r3 from the serialized scheduler word stream.
// Optional abort statistics (err_cnt, err_pulse) when DESCHEDULER_ERR_EN is defined.
//
// state | meaning
// HUNT  | discard words until a valid start-of-frame word arrives
// RECV  | channel 0 staged, collecting channels 1..3 into shadow registers
module descheduler
  import desched_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             valid_in,
  input  logic             sof_in,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic             frame_valid,
  output logic [PTR_W-1:0] ptr
`ifdef DESCHEDULER_ERR_EN
  ,
  output logic [7:0]       err_cnt,
  output logic             err_pulse
`endif
);

  localparam logic [PTR_W-1:0] LAST_CH = PTR_W'(NUM_CH - 1);

  state_t           state;
  logic [WIDTH-1:0] s0, s1, s2;
  logic             idle_clr, idle_en, idle_expire;

  assign idle_clr = (state == HUNT) || valid_in;
  assign idle_en  = (state == RECV) && !valid_in;

  desched_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (idle_clr),
    .en     (idle_en),
    .expire (idle_expire)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= HUNT;
      ptr         <= '0;
      s0          <= '0;
      s1          <= '0;
      s2          <= '0;
      r0          <= '0;
      r1          <= '0;
      r2          <= '0;
      r3          <= '0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      case (state)
        HUNT: begin
          if (valid_in && sof_in) begin
            s0    <= data_in;
            ptr   <= PTR_W'(1);
            state <= RECV;
          end
        end
        RECV: begin
          if (valid_in && sof_in) begin
            // Resync: the partial frame is dropped, this word becomes channel 0.
            s0  <= data_in;
            ptr <= PTR_W'(1);
          end else if (valid_in) begin
            if (ptr == LAST_CH) begin
              r0          <= s0;
              r1          <= s1;
              r2          <= s2;
              r3          <= data_in;
              frame_valid <= 1'b1;
              ptr         <= '0;
              state       <= HUNT;
            end else if (ptr == PTR_W'(1)) begin
              s1  <= data_in;
              ptr <= PTR_W'(2);
            end else if (ptr == PTR_W'(2)) begin
              s2  <= data_in;
              ptr <= LAST_CH;
            end else begin
              ptr   <= '0;
              state <= HUNT;
            end
          end else if (idle_expire) begin
            ptr   <= '0;
            state <= HUNT;
          end
        end
        default: begin
          ptr   <= '0;
          state <= HUNT;
        end
      endcase
    end
  end

`ifdef DESCHEDULER_ERR_EN
  logic abort;

  assign abort = (state == RECV) && ((valid_in && sof_in) || idle_expire);

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt   <= '0;
      err_pulse <= 1'b0;
    end else begin
      err_pulse <= abort;
      if (abort && (err_cnt != 8'hff)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end
`endif

endmodule

// File: doc/descheduler.md
Name: descheduler

Overview:
- Receive-side counterpart of the 4-channel scheduler: takes the scheduler's serialized 16-bit word stream and rebuilds the four channel registers r0..r3.
- A start-of-frame marker aligns channel 0. Words are staged in shadow registers, and all four outputs are committed atomically when a frame completes.
- Sits at the far end of the scheduler link, feeding per-channel consumers.

Parameters:
- WIDTH, 16, data word width (matches the scheduler's r*/data_out width).
- TIMEOUT, 16, consecutive idle cycles in RECV before a partial frame is abandoned; legal range 2..255.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-low reset; rst==0 at posedge resets the block.
- data_in  in  WIDTH  serialized word from the scheduler link.
- valid_in  in  1  data_in is valid this cycle.
- sof_in  in  1  qualifies data_in as channel 0 (frame start); meaningful only with valid_in.
- r0, r1, r2, r3  out  WIDTH  reconstructed channel words; hold their value between frames.
- frame_valid  out  1  one-cycle pulse, asserted in the cycle in which r0..r3 show a newly committed frame.
- ptr  out  2  next expected channel index (debug/observability).

Behaviour:
- Reset (rst==0 at posedge): r0..r3=0, shadow s0..s2=0, frame_valid=0, ptr=0, idle counter=0, state=HUNT.
- States: HUNT (discard until frame start) and RECV (collect channels 1..3).
- HUNT:
  - valid_in&&sof_in: s0<=data_in, ptr<=1, go to RECV.
  - All other inputs are ignored.
- RECV, valid_in&&!sof_in:
  - ptr 1 or 2: s[ptr]<=data_in, ptr++.
  - ptr==3: r0..r2<=s0..s2 and r3<=data_in, all in the same edge; frame_valid<=1 for one cycle; ptr<=0; go to HUNT.
- RECV, valid_in&&sof_in (resync): abort the partial frame, s0<=data_in, ptr<=1, stay in RECV; r* unchanged; no frame_valid.
- RECV, !valid_in: idle counter++.
  - When the counter reaches TIMEOUT-1 and another idle cycle occurs (TIMEOUT consecutive idle cycles), go to HUNT at that edge with ptr<=0 and counter<=0.
  - Any valid_in clears the counter.
- sof_in without valid_in is ignored in every state.
- Latency: frame_valid and updated r* appear on the edge that samples the 4th word, i.e. visible the cycle after that word is presented.
- Back-to-back frames are supported: a sof word in the cycle right after a frame's 4th word starts the next frame with no bubble.
- Outputs are registered; no combinational path from inputs to outputs.
- Reset mid-frame: the partial frame is discarded, r* cleared, state HUNT.

Optional Feature:
- Macro DESCHEDULER_ERR_EN.
- Defined:
  - Adds output err_cnt (8 bits): saturating count (stops at 255) of aborted frames, where an abort is a resync sof in RECV or a timeout in RECV.
  - Adds output err_pulse (1 bit): one-cycle pulse, registered, asserted on each abort.
  - Both reset to 0.
- Not defined: these ports and their logic are absent; aborts are silent. Core behaviour is identical.

Decomposition:
- Shared package desched_pkg:
  - State encoding HUNT=1'b0, RECV=1'b1.
  - NUM_CH=4, PTR_W=2.
  - Default WIDTH/TIMEOUT constants, shared with the scheduler.
- One natural sub-module, desched_idle_timer: idle counter with clear/enable inputs and a timeout-strobe output, parameterized by TIMEOUT.

Test Plan:
- Reset: hold rst=0 for 2 cycles with random valid traffic -> r0..r3=0000, frame_valid=0, ptr=0.
- Clean frame: sof aaaa, then bbbb, cccc, dddd on consecutive cycles -> one cycle after dddd, r0..r3=aaaa,bbbb,cccc,dddd and frame_valid high for exactly 1 cycle; r* unchanged before that.
- Gapped frame: same words with 3 idle cycles between each (less than TIMEOUT) -> identical result, single frame_valid, no early output change.
- Resync: sof 1111, 2222, then sof aaaa, bbbb, cccc, dddd -> exactly one frame_valid, r0..r3=aaaa..dddd; with ERR_EN, err_cnt=1 and one err_pulse.
- Timeout: after a committed frame, sof 1111, 2222, then 16 idle cycles, then 3333, 4444 without sof -> ptr=0, no frame_valid, r* hold the previous frame; repeat with 15 idle cycles plus 3333, 4444 -> frame 1111,2222,3333,4444 commits.
- Reset mid-frame: sof 1111, 2222, then rst=0 for 1 cycle, then bbbb, cccc, dddd without sof -> r*=0, no frame_valid, state HUNT.
